// File: rtl/bit_serializer.sv
// bit_serializer: FIFO-buffered parallel-to-serial converter.
// Words are queued in a small FIFO and shifted out MSB first on X. The X
// stream feeds a downstream sequence-detector FSM. Between words the block can
// insert GAP_CYCLES idle cycles.
// Optional feature: define SER_PARITY_EN to append one even-parity bit after
// each word. In that build, word_done marks the parity cycle.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     X,
  output logic                     x_valid,
  output logic                     word_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] ONE_BIT    = BIT_W'(1);
  localparam logic [3:0]       GAP_LOAD   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit               HAS_GAP    = (GAP_CYCLES > 0);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  // Serializer state
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bitCnt;
  logic [3:0]       r_gapCnt;
  logic             r_x;
  logic             r_xValid;
  logic             r_wordDone;
`ifdef SER_PARITY_EN
  logic             r_parity;
`endif

  logic             w_write;
  logic             w_pop;
  logic             w_decide;
  logic [WIDTH-1:0] w_head;

  // Everything downstream sees comes straight from registers.
  assign din_ready  = (r_count < FULL_COUNT);
  assign fifo_count = r_count;
  assign X          = r_x;
  assign x_valid    = r_xValid;
  assign word_done  = r_wordDone;

  assign w_head  = r_mem[r_rdPtr];
  assign w_write = din_valid && din_ready && !clear;
  assign w_pop   = w_decide && (r_count != '0) && !clear;

  // Decide whether the FSM may start a new word this cycle, given queued data.
  // Taking a word straight out of the final SHIFT cycle avoids a bubble
  // between back-to-back words.
  always_comb begin
    w_decide = 1'b0;
    case (r_state)
      IDLE:    w_decide = 1'b1;
`ifndef SER_PARITY_EN
      SHIFT:   w_decide = (r_bitCnt == '0) && !HAS_GAP;
`else
      PAR:     w_decide = !HAS_GAP;
`endif
      GAP:     w_decide = (r_gapCnt == 4'd0);
      default: w_decide = 1'b0;
    endcase
  end

  // FIFO data array; reset is not needed because count gates every read.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // FIFO pointers and occupancy. A write and a pop in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Serializer FSM. The outputs are registered, so popping a word presents its
  // MSB on the same edge. r_shift then holds the remaining bits, and r_bitCnt
  // counts the bits still to come after the one on X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
      r_x        <= 1'b0;
      r_xValid   <= 1'b0;
      r_wordDone <= 1'b0;
`ifdef SER_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (clear) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
      r_x        <= 1'b0;
      r_xValid   <= 1'b0;
      r_wordDone <= 1'b0;
`ifdef SER_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (w_pop) begin
      r_state    <= SHIFT;
      r_x        <= w_head[WIDTH-1];
      r_xValid   <= 1'b1;
      r_wordDone <= 1'b0;
      r_shift    <= w_head << 1;
      r_bitCnt   <= LAST_BIT;
`ifdef SER_PARITY_EN
      r_parity   <= ^w_head;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_x        <= 1'b0;
          r_xValid   <= 1'b0;
          r_wordDone <= 1'b0;
        end
        SHIFT: begin
          if (r_bitCnt != '0) begin
            r_x        <= r_shift[WIDTH-1];
            r_xValid   <= 1'b1;
            r_shift    <= r_shift << 1;
            r_bitCnt   <= r_bitCnt - 1'b1;
`ifdef SER_PARITY_EN
            r_wordDone <= 1'b0;
`else
            r_wordDone <= (r_bitCnt == ONE_BIT);
`endif
          end else begin
`ifdef SER_PARITY_EN
            r_state    <= PAR;
            r_x        <= r_parity;
            r_xValid   <= 1'b1;
            r_wordDone <= 1'b1;
`else
            r_state    <= HAS_GAP ? GAP : IDLE;
            r_gapCnt   <= GAP_LOAD;
            r_x        <= 1'b0;
            r_xValid   <= 1'b0;
            r_wordDone <= 1'b0;
`endif
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          r_state    <= HAS_GAP ? GAP : IDLE;
          r_gapCnt   <= GAP_LOAD;
          r_x        <= 1'b0;
          r_xValid   <= 1'b0;
          r_wordDone <= 1'b0;
        end
`endif
        GAP: begin
          if (r_gapCnt != 4'd0) begin
            r_gapCnt <= r_gapCnt - 1'b1;
          end else begin
            r_state <= IDLE;
          end
          r_x        <= 1'b0;
          r_xValid   <= 1'b0;
          r_wordDone <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_x        <= 1'b0;
          r_xValid   <= 1'b0;
          r_wordDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per word (2..32).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO depth in words (power of two, >=2).
REQ-003 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between words (0..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port clear  input  1  synchronous flush: empties FIFO and aborts any word in progress.
REQ-007 SHALL have port din  input  WIDTH  parallel pattern word, transmitted MSB first.
REQ-008 SHALL have port din_valid  input  1  din presented for write.
REQ-009 SHALL have port din_ready  output  1  FIFO can accept a word this cycle.
REQ-010 SHALL have port X  output  1  serial bit stream driving the downstream sequence-detector FSM input X.
REQ-011 SHALL have port x_valid  output  1  X carries a data (or parity) bit this cycle.
REQ-012 SHALL have port word_done  output  1  one-cycle pulse during the final bit of a word.
REQ-013 SHALL have port fifo_count  output  $clog2(DEPTH)+1  words currently held in the FIFO.

Function
REQ-014 Write SHALL occur on a rising edge where din_valid=1 and din_ready=1; din_ready SHALL equal (fifo_count<DEPTH), registered-state derived.
REQ-015 FSM states SHALL be IDLE, SHIFT, PAR (parity build only), GAP.
REQ-016 IDLE: X=0, x_valid=0; if fifo_count>0, pop head into shift register, load bit counter WIDTH-1, go SHIFT.
REQ-017 SHIFT: X = shift-register MSB, x_valid=1, one bit per clock; shift left each cycle; counter decrements.
REQ-018 When the counter is 0 in SHIFT, word_done SHALL be 1 that cycle; next state PAR if parity built, else GAP if GAP_CYCLES>0, else SHIFT with the next word popped if fifo_count>0 (back-to-back, no bubble), else IDLE.
REQ-019 GAP: X=0, x_valid=0 for exactly GAP_CYCLES cycles, then behave as IDLE decision.
REQ-020 Latency: a word written at edge N into an empty FIFO with FSM in IDLE SHALL present its MSB on X after edge N+1; its last bit after edge N+WIDTH.
REQ-021 X, x_valid and word_done SHALL be registered outputs; X SHALL be 0 whenever x_valid=0.
REQ-022 Simultaneous write and pop in one cycle SHALL leave fifo_count unchanged; writes while full are impossible (din_ready=0) and ignored.
REQ-023 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-024 clear=1 SHALL at next edge set fifo_count=0, state IDLE, X=0, x_valid=0, word_done=0; a write in the same cycle SHALL be discarded; clear SHALL take priority over all other activity.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, fifo_count=0, pointers 0, shift register 0, X=0, x_valid=0, word_done=0; din_ready SHALL then read 1.
REQ-026 Reset asserted mid-word SHALL abandon the word with no further bits emitted; the first word after deassertion SHALL start per REQ-020.

Configuration
REQ-027 Macro SER_PARITY_EN defined: after each word's last data bit, state PAR SHALL emit one even-parity bit (XOR of the word) on X with x_valid=1; word_done SHALL move to the PAR cycle.
REQ-028 Macro SER_PARITY_EN undefined: PAR state and parity logic SHALL be absent; words are exactly WIDTH bits.

Verification
REQ-029 Defaults, write 8'b00010011 once -> X after successive edges = 0,0,0,1,0,0,1,1 with x_valid=1, word_done on final 1, then X=0, x_valid=0.
REQ-030 Write 8'hA5 then 8'h3C on consecutive cycles -> 16 contiguous valid bits 1010010100111100, two word_done pulses 8 cycles apart, fifo_count peaks at 1.
REQ-031 Hold din_valid=1 for 6 cycles with output stalled by a long word -> din_ready=0 once fifo_count=4; extra words dropped; exactly 5 words emitted in order.
REQ-032 GAP_CYCLES=3, two words queued -> exactly 3 cycles of x_valid=0 between last bit of word 1 and MSB of word 2.
REQ-033 Assert reset=0 (and separately clear=1) at bit 4 of 8'hFF with 2 words queued -> x_valid=0 immediately (reset) / next edge (clear), fifo_count=0, no further bits.
REQ-034 SER_PARITY_EN defined, write 8'b00010011 -> 9 valid bits ending in parity 1, word_done on the 9th bit.
